// File: rtl/wb_dcache_flush_ctrl.sv
// Write-back dcache flush sequencer: walks every set, writes back valid+dirty ways,
// then clears dirty bits (or invalidates valid lines) with one state update per set.
module wb_dcache_flush_ctrl #(
  parameter int NUM_SETS            = 256,
  parameter int NUM_WAYS            = 8,
  parameter int INVALIDATE_ON_FLUSH = 0,
  localparam int SET_W              = $clog2(NUM_SETS),
  localparam int WAY_W              = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  output logic                tag_req_o,
  input  logic                tag_gnt_i,
  output logic [SET_W-1:0]    tag_set_o,
  input  logic                tag_rvalid_i,
  input  logic [NUM_WAYS-1:0] tag_valid_i,
  input  logic [NUM_WAYS-1:0] tag_dirty_i,
  output logic                wb_req_o,
  input  logic                wb_gnt_i,
  output logic [SET_W-1:0]    wb_set_o,
  output logic [WAY_W-1:0]    wb_way_o,
  input  logic                wb_done_i,
  output logic                upd_req_o,
  input  logic                upd_gnt_i,
  output logic [SET_W-1:0]    upd_set_o,
  output logic [NUM_WAYS-1:0] upd_way_mask_o,
  output logic                upd_inval_o,
  output logic [15:0]         wb_count_o
);

  // Handshake: every req output is held with its payload stable until the matching
  // gnt is seen high in the same cycle; only one request is ever outstanding.

  typedef enum logic [3:0] {
    S_IDLE,
    S_TAG_RD,
    S_TAG_WAIT,
    S_SCAN,
    S_WB_REQ,
    S_WB_WAIT,
    S_UPDATE,
    S_NEXT_SET,
    S_DONE
  } state_t;

  localparam logic INVAL = (INVALIDATE_ON_FLUSH != 0);

  state_t              state_q, state_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [NUM_WAYS-1:0] pend_q, pend_d;
  logic [NUM_WAYS-1:0] vmask_q, vmask_d;
  logic [NUM_WAYS-1:0] clean_q, clean_d;
  logic [15:0]         wb_count_q, wb_count_d;
  logic [NUM_WAYS-1:0] way_bit;
  logic [NUM_WAYS-1:0] upd_mask;

  function automatic logic [WAY_W-1:0] lowest_way(input logic [NUM_WAYS-1:0] m);
    lowest_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (m[i]) lowest_way = WAY_W'(i);
    end
  endfunction

  assign way_bit    = NUM_WAYS'(1) << way_q;
  assign upd_mask   = INVAL ? vmask_q : clean_q;
  assign busy_o     = (state_q != S_IDLE);
  assign wb_count_o = wb_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      set_q      <= '0;
      way_q      <= '0;
      pend_q     <= '0;
      vmask_q    <= '0;
      clean_q    <= '0;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      way_q      <= way_d;
      pend_q     <= pend_d;
      vmask_q    <= vmask_d;
      clean_q    <= clean_d;
      wb_count_q <= wb_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    set_d          = set_q;
    way_d          = way_q;
    pend_d         = pend_q;
    vmask_d        = vmask_q;
    clean_d        = clean_q;
    wb_count_d     = wb_count_q;
    flush_ack_o    = 1'b0;
    tag_req_o      = 1'b0;
    tag_set_o      = '0;
    wb_req_o       = 1'b0;
    wb_set_o       = '0;
    wb_way_o       = '0;
    upd_req_o      = 1'b0;
    upd_set_o      = '0;
    upd_way_mask_o = '0;
    upd_inval_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_req_i) begin
          set_d      = '0;
          wb_count_d = '0;
          state_d    = S_TAG_RD;
        end
      end
      S_TAG_RD: begin
        tag_req_o = 1'b1;
        tag_set_o = set_q;
        if (tag_gnt_i) state_d = S_TAG_WAIT;
      end
      S_TAG_WAIT: begin
        if (tag_rvalid_i) begin
          // dirty bits on invalid ways carry no data worth writing back
          pend_d  = tag_valid_i & tag_dirty_i;
          vmask_d = tag_valid_i;
          clean_d = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pend_q != '0) begin
          way_d   = lowest_way(pend_q);
          state_d = S_WB_REQ;
        end else if (upd_mask != '0) begin
          state_d = S_UPDATE;
        end else begin
          state_d = S_NEXT_SET;
        end
      end
      S_WB_REQ: begin
        wb_req_o = 1'b1;
        wb_set_o = set_q;
        wb_way_o = way_q;
        if (wb_gnt_i) begin
          if (wb_count_q != 16'hFFFF) wb_count_d = wb_count_q + 16'd1;
          state_d = S_WB_WAIT;
        end
      end
      S_WB_WAIT: begin
        if (wb_done_i) begin
          pend_d  = pend_q & ~way_bit;
          clean_d = clean_q | way_bit;
          state_d = S_SCAN;
        end
      end
      S_UPDATE: begin
        upd_req_o      = 1'b1;
        upd_set_o      = set_q;
        upd_way_mask_o = upd_mask;
        upd_inval_o    = INVAL;
        if (upd_gnt_i) state_d = S_NEXT_SET;
      end
      S_NEXT_SET: begin
        if (set_q == SET_W'(NUM_SETS - 1)) begin
          state_d = S_DONE;
        end else begin
          set_d   = set_q + SET_W'(1);
          state_d = S_TAG_RD;
        end
      end
      S_DONE: begin
        flush_ack_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
// Directed bench for wb_dcache_flush_ctrl: three instances cover clear-dirty,
// invalidate-on-flush and a 256-set counter saturation run.
module tb_wb_dcache_flush_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_wb(input int s, input int w);
    return 32'((s << 8) | w);
  endfunction

  function automatic logic [31:0] enc_upd(input int s, input int m, input int inv);
    return 32'((s << 16) | (m << 4) | inv);
  endfunction

  // shared tag array contents for the 4x4 instances
  logic [3:0] valid_mem [4];
  logic [3:0] dirty_mem [4];

  // ---------------- instance A: 4 sets, 4 ways, clear dirty ----------------
  logic       req_a, ack_a, busy_a, tag_req_a, tag_gnt_a, rv_a = 1'b0;
  logic [1:0] tag_set_a, rd_set_a = '0;
  logic [3:0] tag_valid_a, tag_dirty_a;
  logic       wb_req_a, wb_gnt_a, wb_done_a, wb_wait_a = 1'b0;
  logic [1:0] wb_set_a, wb_way_a;
  logic       upd_req_a, upd_gnt_a, upd_inval_a;
  logic [1:0] upd_set_a;
  logic [3:0] upd_mask_a;
  logic [15:0] wb_count_a;
  int gnt_delay = 0, done_delay = 1, gnt_cnt_a = 0, done_cnt_a = 0;
  int stab_err = 0, ovl_err = 0;
  logic       pend_prev = 1'b0;
  logic [1:0] pset = '0, pway = '0;
  logic [31:0] wb_log_a[$], upd_log_a[$], exp_wb_q[$], exp_upd_q[$];

  assign tag_valid_a = valid_mem[rd_set_a];
  assign tag_dirty_a = dirty_mem[rd_set_a];
  assign tag_gnt_a   = tag_req_a;
  assign upd_gnt_a   = upd_req_a;
  assign wb_gnt_a    = wb_req_a && (gnt_cnt_a == gnt_delay);
  assign wb_done_a   = wb_wait_a && (done_cnt_a == done_delay);

  wb_dcache_flush_ctrl #(.NUM_SETS(4), .NUM_WAYS(4), .INVALIDATE_ON_FLUSH(0)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_req_i(req_a), .flush_ack_o(ack_a), .busy_o(busy_a),
    .tag_req_o(tag_req_a), .tag_gnt_i(tag_gnt_a), .tag_set_o(tag_set_a), .tag_rvalid_i(rv_a),
    .tag_valid_i(tag_valid_a), .tag_dirty_i(tag_dirty_a),
    .wb_req_o(wb_req_a), .wb_gnt_i(wb_gnt_a), .wb_set_o(wb_set_a), .wb_way_o(wb_way_a),
    .wb_done_i(wb_done_a), .upd_req_o(upd_req_a), .upd_gnt_i(upd_gnt_a), .upd_set_o(upd_set_a),
    .upd_way_mask_o(upd_mask_a), .upd_inval_o(upd_inval_a), .wb_count_o(wb_count_a)
  );

  always @(posedge clk) begin
    if (tag_req_a && tag_gnt_a) rd_set_a <= tag_set_a;
    rv_a      <= tag_req_a && tag_gnt_a && !rst;
    gnt_cnt_a <= (wb_req_a && !wb_gnt_a && !rst) ? gnt_cnt_a + 1 : 0;
    if (rst) wb_wait_a <= 1'b0;
    else if (wb_req_a && wb_gnt_a) begin
      wb_wait_a  <= 1'b1;
      done_cnt_a <= 1;
    end else if (wb_wait_a) begin
      if (wb_done_a) wb_wait_a <= 1'b0;
      else done_cnt_a <= done_cnt_a + 1;
    end
    if (!rst && wb_req_a && wb_gnt_a) wb_log_a.push_back(enc_wb(wb_set_a, wb_way_a));
    if (!rst && upd_req_a && upd_gnt_a) upd_log_a.push_back(enc_upd(upd_set_a, upd_mask_a, upd_inval_a));
    pend_prev <= wb_req_a && !wb_gnt_a && !rst;
    pset      <= wb_set_a;
    pway      <= wb_way_a;
  end

  // protocol monitor: held payload while waiting for grant, one request at a time
  always @(posedge clk) begin
    if (!rst && pend_prev && !(wb_req_a && wb_set_a == pset && wb_way_a == pway)) stab_err++;
    if (!rst && ((int'(tag_req_a) + int'(wb_req_a) + int'(upd_req_a) > 1) || (wb_req_a && wb_wait_a)))
      ovl_err++;
  end

  // ---------------- instance B: 4 sets, 4 ways, invalidate ----------------
  logic       req_b, ack_b, busy_b, tag_req_b, tag_gnt_b, rv_b = 1'b0;
  logic [1:0] tag_set_b, rd_set_b = '0;
  logic [3:0] tag_valid_b, tag_dirty_b;
  logic       wb_req_b, wb_gnt_b, wb_done_b = 1'b0;
  logic [1:0] wb_set_b, wb_way_b;
  logic       upd_req_b, upd_gnt_b, upd_inval_b;
  logic [1:0] upd_set_b;
  logic [3:0] upd_mask_b;
  logic [15:0] wb_count_b;
  logic [31:0] wb_log_b[$], upd_log_b[$];

  assign tag_valid_b = valid_mem[rd_set_b];
  assign tag_dirty_b = dirty_mem[rd_set_b];
  assign tag_gnt_b   = tag_req_b;
  assign wb_gnt_b    = wb_req_b;
  assign upd_gnt_b   = upd_req_b;

  wb_dcache_flush_ctrl #(.NUM_SETS(4), .NUM_WAYS(4), .INVALIDATE_ON_FLUSH(1)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_req_i(req_b), .flush_ack_o(ack_b), .busy_o(busy_b),
    .tag_req_o(tag_req_b), .tag_gnt_i(tag_gnt_b), .tag_set_o(tag_set_b), .tag_rvalid_i(rv_b),
    .tag_valid_i(tag_valid_b), .tag_dirty_i(tag_dirty_b),
    .wb_req_o(wb_req_b), .wb_gnt_i(wb_gnt_b), .wb_set_o(wb_set_b), .wb_way_o(wb_way_b),
    .wb_done_i(wb_done_b), .upd_req_o(upd_req_b), .upd_gnt_i(upd_gnt_b), .upd_set_o(upd_set_b),
    .upd_way_mask_o(upd_mask_b), .upd_inval_o(upd_inval_b), .wb_count_o(wb_count_b)
  );

  always @(posedge clk) begin
    if (tag_req_b && tag_gnt_b) rd_set_b <= tag_set_b;
    rv_b      <= tag_req_b && tag_gnt_b && !rst;
    wb_done_b <= wb_req_b && wb_gnt_b && !rst;
    if (!rst && wb_req_b && wb_gnt_b) wb_log_b.push_back(enc_wb(wb_set_b, wb_way_b));
    if (!rst && upd_req_b && upd_gnt_b) upd_log_b.push_back(enc_upd(upd_set_b, upd_mask_b, upd_inval_b));
  end

  // ---------------- instance C: 256 sets, 2 ways, saturation ----------------
  logic       req_c, ack_c, busy_c, tag_req_c, tag_gnt_c, rv_c = 1'b0;
  logic [7:0] tag_set_c, rd_set_c = '0;
  logic [1:0] tag_valid_c, tag_dirty_c;
  logic       wb_req_c, wb_gnt_c, wb_done_c = 1'b0;
  logic [7:0] wb_set_c, upd_set_c;
  logic [0:0] wb_way_c;
  logic       upd_req_c, upd_gnt_c, upd_inval_c;
  logic [1:0] upd_mask_c;
  logic [15:0] wb_count_c;
  int wbc_n = 0, updc_n = 0, updc_bad = 0;

  // 44 sets with both ways dirty + 212 with one = 300 writebacks
  assign tag_valid_c = 2'b11;
  assign tag_dirty_c = (rd_set_c < 8'd44) ? 2'b11 : 2'b01;
  assign tag_gnt_c   = tag_req_c;
  assign wb_gnt_c    = wb_req_c;
  assign upd_gnt_c   = upd_req_c;

  wb_dcache_flush_ctrl #(.NUM_SETS(256), .NUM_WAYS(2), .INVALIDATE_ON_FLUSH(0)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_req_i(req_c), .flush_ack_o(ack_c), .busy_o(busy_c),
    .tag_req_o(tag_req_c), .tag_gnt_i(tag_gnt_c), .tag_set_o(tag_set_c), .tag_rvalid_i(rv_c),
    .tag_valid_i(tag_valid_c), .tag_dirty_i(tag_dirty_c),
    .wb_req_o(wb_req_c), .wb_gnt_i(wb_gnt_c), .wb_set_o(wb_set_c), .wb_way_o(wb_way_c),
    .wb_done_i(wb_done_c), .upd_req_o(upd_req_c), .upd_gnt_i(upd_gnt_c), .upd_set_o(upd_set_c),
    .upd_way_mask_o(upd_mask_c), .upd_inval_o(upd_inval_c), .wb_count_o(wb_count_c)
  );

  always @(posedge clk) begin
    if (tag_req_c && tag_gnt_c) rd_set_c <= tag_set_c;
    rv_c      <= tag_req_c && tag_gnt_c && !rst;
    wb_done_c <= wb_req_c && wb_gnt_c && !rst;
    if (!rst && wb_req_c && wb_gnt_c) wbc_n++;
    if (!rst && upd_req_c && upd_gnt_c) begin
      updc_n++;
      if (upd_mask_c != ((upd_set_c < 8'd44) ? 2'b11 : 2'b01) || upd_inval_c || wb_set_c != 8'd0) updc_bad++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_mem(input logic [15:0] v, input logic [15:0] d);
    for (int i = 0; i < 4; i++) begin
      valid_mem[i] = v[i*4 +: 4];
      dirty_mem[i] = d[i*4 +: 4];
    end
  endtask

  task automatic check_idle_a(input string p);
    check_eq({p, "_busy"}, busy_a, 0);
    check_eq({p, "_ack"}, ack_a, 0);
    check_eq({p, "_tag_req"}, tag_req_a, 0);
    check_eq({p, "_tag_set"}, tag_set_a, 0);
    check_eq({p, "_wb_req"}, wb_req_a, 0);
    check_eq({p, "_wb_set_way"}, {wb_set_a, wb_way_a}, 0);
    check_eq({p, "_upd_req"}, upd_req_a, 0);
    check_eq({p, "_upd_set_mask_inv"}, {upd_set_a, upd_mask_a, upd_inval_a}, 0);
    check_eq({p, "_wb_count"}, wb_count_a, 0);
  endtask

  // accept a flush on A; n counts cycles after the accept edge until ack is seen
  task automatic run_flush_a(input string p, input int exp_n);
    int n;
    @(negedge clk) req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(negedge clk);
    n = 1;
    check_eq({p, "_start_busy"}, busy_a, 1);
    check_eq({p, "_start_tag"}, {tag_req_a, tag_set_a}, {1'b1, 2'd0});
    while (!ack_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({p, "_ack_cycle"}, n, exp_n);
    check_eq({p, "_busy_in_done"}, busy_a, 1);
    @(negedge clk);
    check_eq({p, "_ack_width"}, ack_a, 0);
    check_eq({p, "_idle_busy"}, busy_a, 0);
  endtask

  task automatic check_logs_a(input string p);
    check_eq({p, "_wb_n"}, wb_log_a.size(), exp_wb_q.size());
    for (int i = 0; i < exp_wb_q.size() && i < wb_log_a.size(); i++)
      check_eq({p, "_wb"}, wb_log_a[i], exp_wb_q[i]);
    check_eq({p, "_upd_n"}, upd_log_a.size(), exp_upd_q.size());
    for (int i = 0; i < exp_upd_q.size() && i < upd_log_a.size(); i++)
      check_eq({p, "_upd"}, upd_log_a[i], exp_upd_q[i]);
    wb_log_a.delete(); upd_log_a.delete(); exp_wb_q.delete(); exp_upd_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    int n;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    set_mem(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    check_idle_a("reset");
    check_eq("reset_b_c_busy", {busy_b, busy_c, ack_b, ack_c}, 0);
    rst = 1'b0;

    // all clean, immediate responses: 4 sets x 4 cycles, ack in cycle 17
    set_mem(16'hFFFF, 16'h0000);
    run_flush_a("clean", 17);
    check_eq("clean_count", wb_count_a, 0);
    check_logs_a("clean");

    // set2 valid=1011 dirty=1010; set1 empty; set3 valid=0110 clean
    set_mem(16'h6B0F, 16'h0A00);
    exp_wb_q.push_back(enc_wb(2, 1));
    exp_wb_q.push_back(enc_wb(2, 3));
    exp_upd_q.push_back(enc_upd(2, 4'b1010, 0));
    run_flush_a("dirty", 24);
    check_eq("dirty_count", wb_count_a, 2);
    check_logs_a("dirty");
    check_eq("dirty_count_hold", wb_count_a, 2);

    // same tags with invalidate-on-flush: every set with valid!=0 is updated
    @(negedge clk) req_b = 1'b1;
    @(posedge clk);
    #1 req_b = 1'b0;
    n = 0;
    while (!ack_b && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("inv_ack_cycle", n, 26);
    check_eq("inv_count", wb_count_b, 2);
    check_eq("inv_wb_n", wb_log_b.size(), 2);
    if (wb_log_b.size() == 2) begin
      check_eq("inv_wb0", wb_log_b[0], enc_wb(2, 1));
      check_eq("inv_wb1", wb_log_b[1], enc_wb(2, 3));
    end
    check_eq("inv_upd_n", upd_log_b.size(), 3);
    if (upd_log_b.size() == 3) begin
      check_eq("inv_upd0", upd_log_b[0], enc_upd(0, 4'b1111, 1));
      check_eq("inv_upd1", upd_log_b[1], enc_upd(2, 4'b1011, 1));
      check_eq("inv_upd2", upd_log_b[2], enc_upd(3, 4'b0110, 1));
    end

    // slow grant/done; dirty bit on invalid way 3 of set1 must be ignored
    gnt_delay = 5; done_delay = 7;
    set_mem(16'h0071, 16'h0081);
    exp_wb_q.push_back(enc_wb(0, 0));
    exp_upd_q.push_back(enc_upd(0, 4'b0001, 0));
    run_flush_a("slow", 32);
    check_eq("slow_count", wb_count_a, 1);
    check_logs_a("slow");
    check_eq("slow_stable", stab_err, 0);
    check_eq("slow_one_outstanding", ovl_err, 0);
    gnt_delay = 0;

    // reset while waiting for writeback completion on set 1
    done_delay = 20;
    set_mem(16'hF1FF, 16'h0010);
    @(negedge clk) req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    n = 0;
    while (!wb_wait_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rstmid_wb_seen", wb_wait_a, 1);
    check_eq("rstmid_wb_target", (wb_log_a.size() > 0) ? wb_log_a[wb_log_a.size()-1] : 32'hDEAD, enc_wb(1, 0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_a("rstmid");
    rst = 1'b0;
    wb_log_a.delete(); upd_log_a.delete();
    done_delay = 1;
    set_mem(16'hF1FF, 16'h0000);
    run_flush_a("restart", 17);
    check_eq("restart_count", wb_count_a, 0);
    check_logs_a("restart");

    // request held through DONE: single-cycle ack, then a second flush starts
    set_mem(16'hFFFF, 16'h0000);
    @(negedge clk) req_a = 1'b1;
    @(posedge clk);
    n = 0;
    while (!ack_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("held_ack1_cycle", n, 17);
    @(negedge clk);
    check_eq("held_ack_width", ack_a, 0);
    check_eq("held_idle_busy", busy_a, 0);
    @(negedge clk);
    check_eq("held_restart_busy", busy_a, 1);
    check_eq("held_restart_tag", {tag_req_a, tag_set_a}, {1'b1, 2'd0});
    req_a = 1'b0;
    n = 1;
    while (!ack_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("held_ack2_cycle", n, 17);
    @(negedge clk);
    check_eq("held_ack2_width", ack_a, 0);

    // 300 writebacks with the counter preloaded near the top
    @(negedge clk) req_c = 1'b1;
    @(posedge clk);
    #1 req_c = 1'b0;
    @(negedge clk);
    force u_c.wb_count_q = 16'hFFFE;
    @(negedge clk);
    release u_c.wb_count_q;
    n = 0;
    while (!ack_c && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("sat_ack_seen", ack_c, 1);
    check_eq("sat_count", wb_count_c, 16'hFFFF);
    check_eq("sat_wb_n", wbc_n, 300);
    check_eq("sat_upd_n", updc_n, 256);
    check_eq("sat_upd_fields", updc_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
